// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock, signed or unsigned
// per operation, with valid/ready handshakes on both the operand and result sides.
module seq_divider #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   in_ready_d, out_valid_d;

    logic [WIDTH-1:0] rem_q, quo_q, dvs_mag_q;
    logic             q_neg_q, r_neg_q, ovf_pend_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept, last_step;
    logic             dvd_neg, dvs_neg, ovf_case;
    logic [WIDTH-1:0] dvd_mag, dvs_mag, min_val;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] rem_nxt, quo_nxt;

    // Operand conditioning and one restoring step
    always_comb begin
        accept    = (state_q == IDLE) && in_valid;
        last_step = (state_q == CALC) && (cnt_q == CNT_W'(1));
        min_val   = {1'b1, {(WIDTH-1){1'b0}}};
        dvd_neg   = is_signed && dividend[WIDTH-1];
        dvs_neg   = is_signed && divisor[WIDTH-1];
        dvd_mag   = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
        dvs_mag   = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
        ovf_case  = is_signed && (dividend == min_val) && (divisor == {WIDTH{1'b1}});
        shifted   = {rem_q, quo_q[WIDTH-1]};
        diff      = shifted - {1'b0, dvs_mag_q};
        rem_nxt   = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nxt   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
    end

    // State and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (divisor == '0) ? DONE : CALC;
            CALC: if (last_step) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs follow the state being entered
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state_d)
            IDLE:    in_ready_d  = 1'b1;
            DONE:    out_valid_d = 1'b1;
            default: ;
        endcase
    end

    // Iteration datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_mag_q   <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            ovf_pend_q  <= 1'b0;
            cnt_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            rem_q       <= '0;
            quo_q       <= dvd_mag;
            dvs_mag_q   <= dvs_mag;
            q_neg_q     <= dvd_neg ^ dvs_neg;
            r_neg_q     <= dvd_neg;
            ovf_pend_q  <= ovf_case;
            cnt_q       <= CNT_W'(WIDTH);
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            // Zero divisor skips the iteration and reports the dividend untouched
            if (divisor == '0) begin
                quotient    <= {WIDTH{1'b1}};
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end
        end else if (state_q == CALC) begin
            rem_q <= rem_nxt;
            quo_q <= quo_nxt;
            cnt_q <= cnt_q - CNT_W'(1);
            if (last_step) begin
                quotient  <= q_neg_q ? (~quo_nxt + WIDTH'(1)) : quo_nxt;
                remainder <= r_neg_q ? (~rem_nxt + WIDTH'(1)) : rem_nxt;
                overflow  <= ovf_pend_q;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vector table, handshake corner
// sequences, and a random sweep against an arithmetic reference model.
module tb_seq_divider;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, is_signed;
    logic [W-1:0] dividend, divisor;
    logic         out_valid, out_ready;
    logic [W-1:0] quotient, remainder;
    logic         div_by_zero, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division semantics
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        res_t   m;
        longint sa, sb;
        m.dz = 1'b0;
        m.ov = 1'b0;
        if (b == '0) begin
            m.q  = '1;
            m.r  = a;
            m.dz = 1'b1;
        end else if (s) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            if (sa == -(longint'(1) <<< (W - 1)) && sb == -1) begin
                m.q  = W'(sa);
                m.r  = '0;
                m.ov = 1'b1;
            end else begin
                m.q = W'(sa / sb);
                m.r = W'(sa % sb);
            end
        end else begin
            m.q = a / b;
            m.r = a % b;
        end
        return m;
    endfunction

    // One full transaction: accept, wait for result, optional backpressure, consume
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input int hold, input bit pulse,
                          output res_t got, output int lat);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        is_signed = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (pulse && lat == 5) begin
                chk("in_ready_calc", 32'(in_ready), 32'd0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
        got.q  = quotient;
        got.r  = remainder;
        got.dz = div_by_zero;
        got.ov = overflow;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            chk("hold_q", 32'(quotient), 32'(got.q));
            chk("hold_r", 32'(remainder), 32'(got.r));
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("consume_valid", 32'(out_valid), 32'd0);
        chk("consume_q_kept", 32'(quotient), 32'(got.q));
    endtask

    vec_t vecs[12];
    res_t got, exp_r;
    int   lat;

    initial begin
        vecs[0]  = '{16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 1'b0, 17};
        vecs[1]  = '{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17};
        vecs[2]  = '{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 17};
        vecs[3]  = '{16'd1234, 16'd0,    1'b0, 16'hFFFF, 16'd1234, 1'b1, 1'b0, 1};
        vecs[4]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 17};
        vecs[5]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 17};
        vecs[6]  = '{16'hFFF9, 16'h0000, 1'b1, 16'hFFFF, 16'hFFF9, 1'b1, 1'b0, 1};
        vecs[7]  = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
        vecs[8]  = '{16'h0000, 16'h0005, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 17};
        vecs[9]  = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0, 17};
        vecs[10] = '{16'h7FFF, 16'h8000, 1'b1, 16'h0000, 16'h7FFF, 1'b0, 1'b0, 17};
        vecs[11] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 17};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        is_signed = 1'b0;
        dividend = '0;
        divisor = '0;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dz", 32'(div_by_zero), 32'd0);
        chk("rst_ov", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, 0, 1'b0, got, lat);
            chk($sformatf("vec%0d_q", i), 32'(got.q), 32'(vecs[i].q));
            chk($sformatf("vec%0d_r", i), 32'(got.r), 32'(vecs[i].r));
            chk($sformatf("vec%0d_dz", i), 32'(got.dz), 32'(vecs[i].dz));
            chk($sformatf("vec%0d_ov", i), 32'(got.ov), 32'(vecs[i].ov));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure in DONE with an ignored in_valid pulse during CALC
        run_op(16'd5000, 16'd33, 1'b0, 5, 1'b1, got, lat);
        chk("bp_q", 32'(got.q), 32'd151);
        chk("bp_r", 32'(got.r), 32'd17);
        chk("bp_lat", 32'(lat), 32'd17);

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        dividend = 16'h1234;
        divisor = 16'd3;
        is_signed = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_q", 32'(quotient), 32'd0);
        chk("arst_r", 32'(remainder), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'd65535, 16'd255, 1'b0, 0, 1'b0, got, lat);
        chk("post_rst_q", 32'(got.q), 32'd257);
        chk("post_rst_r", 32'(got.r), 32'd0);
        chk("post_rst_lat", 32'(lat), 32'd17);

        // Random sweep, both modes, with occasional zero / -1 / MIN operands
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] a, b;
            logic         s;
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            case ($urandom_range(0, 7))
                0: b = '0;
                1: b = '1;
                2: a = 16'h8000;
                3: b = W'($urandom_range(1, 15));
                default: ;
            endcase
            exp_r = model(a, b, s);
            run_op(a, b, s, int'($urandom_range(0, 2)), 1'b0, got, lat);
            chk($sformatf("rnd%0d_q a=%0h b=%0h s=%0d", i, a, b, s), 32'(got.q), 32'(exp_r.q));
            chk($sformatf("rnd%0d_r", i), 32'(got.r), 32'(exp_r.r));
            chk($sformatf("rnd%0d_dz", i), 32'(got.dz), 32'(exp_r.dz));
            chk($sformatf("rnd%0d_ov", i), 32'(got.ov), 32'(exp_r.ov));
            chk($sformatf("rnd%0d_lat", i), 32'(lat), (b == '0) ? 32'd1 : 32'd17);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
